// File: rtl/vga_pkg.sv
// Shared definitions for the VGA stream controller: mode encodings, bar
// colours and raster sizing helpers.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_STREAM = 2'd0,
    MODE_BARS   = 2'd1,
    MODE_GRID   = 2'd2,
    MODE_SOLID  = 2'd3
  } mode_e;

  // White, yellow, cyan, green, magenta, red, blue, black as 8:8:8 full scale.
  localparam logic [23:0] BAR_COLOR [0:7] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // Keep the MSBs of each component and repack as {R,G,B}.
  function automatic logic [23:0] bar_pix(input logic [2:0] idx, input int rw, input int gw,
                                          input int bw);
    logic [23:0] c, r, g, b;
    c = BAR_COLOR[idx];
    r = {16'd0, c[23:16]} >> (8 - rw);
    g = {16'd0, c[15:8]}  >> (8 - gw);
    b = {16'd0, c[7:0]}   >> (8 - bw);
    return (r << (gw + bw)) | (g << bw) | b;
  endfunction

  function automatic int span_total(input int sync, input int bp, input int act, input int fp);
    return sync + bp + act + fp;
  endfunction

endpackage

// File: rtl/vga_stream_ctrl_if.sv
// FIFO read port, mode controls and video pins of the stream controller.
interface vga_stream_ctrl_if #(
  parameter int PIX_W = 8,
  parameter int XW    = 10,
  parameter int YW    = 9
);
  logic [1:0]       mode;
  logic [PIX_W-1:0] solid_color;
  logic             fifo_rd_en;
  logic             fifo_empty;
  logic [PIX_W-1:0] fifo_rd_data;
  logic             hsync, vsync, de;
  logic [PIX_W-1:0] rgb;
  logic [XW-1:0]    x_addr;
  logic [YW-1:0]    y_addr;
  logic             frame_start;
  logic             underflow;

  modport master (
    input  mode, solid_color, fifo_empty, fifo_rd_data,
    output fifo_rd_en, hsync, vsync, de, rgb, x_addr, y_addr, frame_start, underflow
  );

  modport slave (
    output mode, solid_color, fifo_empty, fifo_rd_data,
    input  fifo_rd_en, hsync, vsync, de, rgb, x_addr, y_addr, frame_start, underflow
  );
endinterface

// File: rtl/vga_timing_core.sv
// Raster counters with sync, active-area and frame-end decode; all outputs
// describe the current counter position (before any pipeline delay).
module vga_timing_core import vga_pkg::*; #(
  parameter int H_SYNC = 96, H_BP = 48, H_ACT = 640, H_FP = 16,
  parameter int V_SYNC = 2,  V_BP = 33, V_ACT = 480, V_FP = 10,
  parameter int XW = 10, YW = 9
) (
  input  logic          Sys_clk,
  input  logic          Rst_n,
  output logic          hs,
  output logic          vs,
  output logic          active,
  output logic          frame_end,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y
);
  localparam int H_TOTAL = span_total(H_SYNC, H_BP, H_ACT, H_FP);
  localparam int V_TOTAL = span_total(V_SYNC, V_BP, V_ACT, V_FP);
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNCE = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACTS  = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_ACTE  = HW'(H_SYNC + H_BP + H_ACT);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNCE = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACTS  = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_ACTE  = VW'(V_SYNC + V_BP + V_ACT);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_wrap, v_last, h_act, v_act;

  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    v_last  = (v_cnt_q == V_LAST);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;

    hs        = (h_cnt_q < H_SYNCE);
    vs        = (v_cnt_q < V_SYNCE);
    h_act     = (h_cnt_q >= H_ACTS) && (h_cnt_q < H_ACTE);
    v_act     = (v_cnt_q >= V_ACTS) && (v_cnt_q < V_ACTE);
    active    = h_act && v_act;
    frame_end = h_wrap && v_last;
    x         = active ? XW'(h_cnt_q - H_ACTS) : '0;
    y         = active ? YW'(v_cnt_q - V_ACTS) : '0;
  end

  always_ff @(posedge Sys_clk or negedge Rst_n) begin
    if (!Rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end
endmodule

// File: rtl/vga_stream_ctrl.sv
// VGA/DVI raster controller: FIFO pixel streaming or test patterns, with a
// read-latency delay line so FIFO data lands on the registered DE.
module vga_stream_ctrl import vga_pkg::*; #(
  parameter int H_SYNC = 96, H_BP = 48, H_ACT = 640, H_FP = 16,
  parameter int V_SYNC = 2,  V_BP = 33, V_ACT = 480, V_FP = 10,
  parameter bit HS_POL = 1'b0, VS_POL = 1'b0,
  parameter int R_W = 3, G_W = 3, B_W = 2,
  parameter int RD_LAT = 1
) (
  input  logic               Sys_clk,
  input  logic               Rst_n,
  vga_stream_ctrl_if.master  bus
);
  localparam int PIX_W = R_W + G_W + B_W;
  localparam int XW    = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int YW    = (V_ACT > 1) ? $clog2(V_ACT) : 1;
  localparam int BAR_W = (H_ACT / 8 > 0) ? H_ACT / 8 : 1;

  typedef struct packed {
    logic             hs, vs, de;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic             bad, first, stream;
    logic [PIX_W-1:0] pix;
  } stage_t;

  logic          hs, vs, active, frame_end;
  logic [XW-1:0] x;
  logic [YW-1:0] y;

  vga_timing_core #(
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT), .H_FP(H_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP),
    .XW(XW), .YW(YW)
  ) u_core (
    .Sys_clk(Sys_clk), .Rst_n(Rst_n), .hs(hs), .vs(vs), .active(active),
    .frame_end(frame_end), .x(x), .y(y)
  );

  // Mode only changes at the last counter position so a frame is never mixed.
  mode_e latched_mode_q, latched_mode_d;
  logic  stream;
  assign latched_mode_d  = frame_end ? mode_e'(bus.mode) : latched_mode_q;
  assign stream          = (latched_mode_q == MODE_STREAM);
  assign bus.fifo_rd_en  = active && stream;

  logic [PIX_W-1:0] pat;
  int               xi, yi;
  stage_t           cur, tail;

  always_comb begin
    xi  = int'(x);
    yi  = int'(y);
    pat = '0;
    case (latched_mode_q)
      MODE_BARS:  if (xi < 8 * BAR_W) pat = PIX_W'(bar_pix(3'(xi / BAR_W), R_W, G_W, B_W));
      MODE_GRID:  pat = (((xi & 15) == 0) || ((yi & 15) == 0)) ? '1 : '0;
      MODE_SOLID: pat = bus.solid_color;
      default:    pat = '0;
    endcase

    cur        = '0;
    cur.hs     = hs;
    cur.vs     = vs;
    cur.de     = active;
    cur.x      = x;
    cur.y      = y;
    cur.bad    = bus.fifo_rd_en && bus.fifo_empty;
    cur.first  = active && (x == '0) && (y == '0);
    cur.stream = stream;
    cur.pix    = pat;
  end

  if (RD_LAT == 0) begin : g_nodly
    assign tail = cur;
  end else begin : g_dly
    stage_t dl_q [RD_LAT];
    stage_t dl_d [RD_LAT];
    always_comb begin
      dl_d[0] = cur;
      for (int i = 1; i < RD_LAT; i++) dl_d[i] = dl_q[i-1];
    end
    always_ff @(posedge Sys_clk or negedge Rst_n) begin
      if (!Rst_n) for (int i = 0; i < RD_LAT; i++) dl_q[i] <= '0;
      else        dl_q <= dl_d;
    end
    assign tail = dl_q[RD_LAT-1];
  end

  logic             hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic             fs_q, fs_d, underflow_q, underflow_d;
  logic [PIX_W-1:0] rgb_q, rgb_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;

  // FIFO data is valid exactly when its request reaches the delay-line tail.
  always_comb begin
    hsync_d = tail.hs ? HS_POL : ~HS_POL;
    vsync_d = tail.vs ? VS_POL : ~VS_POL;
    de_d    = tail.de;
    x_d     = tail.x;
    y_d     = tail.y;
    fs_d    = tail.first;
    rgb_d   = '0;
    if (tail.de && !tail.bad) rgb_d = tail.stream ? bus.fifo_rd_data : tail.pix;
    underflow_d = tail.bad | (underflow_q & ~tail.first);
  end

  always_ff @(posedge Sys_clk or negedge Rst_n) begin
    if (!Rst_n) begin
      latched_mode_q <= MODE_STREAM;
      hsync_q        <= ~HS_POL;
      vsync_q        <= ~VS_POL;
      de_q           <= 1'b0;
      rgb_q          <= '0;
      x_q            <= '0;
      y_q            <= '0;
      fs_q           <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      latched_mode_q <= latched_mode_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      de_q           <= de_d;
      rgb_q          <= rgb_d;
      x_q            <= x_d;
      y_q            <= y_d;
      fs_q           <= fs_d;
      underflow_q    <= underflow_d;
    end
  end

  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.de          = de_q;
  assign bus.rgb         = rgb_q;
  assign bus.x_addr      = x_q;
  assign bus.y_addr      = y_q;
  assign bus.frame_start = fs_q;
  assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_vga_stream_ctrl.sv
// Bench for vga_stream_ctrl on a tiny 14x7 raster: every cycle is compared
// against a raster model derived from the cycle count since reset release.
module tb_vga_stream_ctrl;
  localparam int HT = 14, VT = 7, FT = HT * VT, LAT = 2;
  localparam logic [7:0] BARS [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};

  logic Sys_clk = 1'b0;
  logic Rst_n   = 1'b0;
  always #5 Sys_clk = ~Sys_clk;

  vga_stream_ctrl_if #(.PIX_W(8), .XW(3), .YW(2)) bus ();

  vga_stream_ctrl #(
    .H_SYNC(2), .H_BP(2), .H_ACT(8), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_ACT(4), .V_FP(1), .RD_LAT(1)
  ) dut (
    .Sys_clk(Sys_clk), .Rst_n(Rst_n), .bus(bus)
  );

  int total = 0, bad = 0;
  int n, sc, fcnt;
  logic uexp;
  logic [1:0] mode_h  [4096];
  logic       empty_h [4096];
  logic [7:0] solid_h [4096];

  function automatic logic [1:0] frame_mode(int f);
    return (f == 0) ? 2'd0 : mode_h[f * FT - 1];
  endfunction

  function automatic logic in_active(int h, int v);
    return (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_hsync"}, 32'(bus.hsync), 32'd1);
    check({tag, "_vsync"}, 32'(bus.vsync), 32'd1);
    check({tag, "_de"}, 32'(bus.de), 32'd0);
    check({tag, "_rgb"}, 32'(bus.rgb), 32'd0);
    check({tag, "_x"}, 32'(bus.x_addr), 32'd0);
    check({tag, "_y"}, 32'(bus.y_addr), 32'd0);
    check({tag, "_fs"}, 32'(bus.frame_start), 32'd0);
    check({tag, "_uf"}, 32'(bus.underflow), 32'd0);
    check({tag, "_rden"}, 32'(bus.fifo_rd_en), 32'd0);
  endtask

  // One pixel clock: record inputs, check rd_en, run the FIFO, check outputs.
  task automatic step();
    int p, h, v;
    logic a, rd_now, fs;
    logic [1:0] m;
    logic [7:0] ex;
    int xe, ye;
    if (n >= 4095) begin
      $display("FAIL history bound at cycle %0d", n);
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "history overflow");
    end
    mode_h[n]  = bus.mode;
    empty_h[n] = bus.fifo_empty;
    solid_h[n] = bus.solid_color;
    check("rd_en", 32'(bus.fifo_rd_en),
          32'(in_active(n % HT, (n / HT) % VT) && frame_mode(n / FT) == 2'd0));
    rd_now = bus.fifo_rd_en;
    @(posedge Sys_clk);
    n++;
    @(negedge Sys_clk);
    bus.fifo_rd_data = 8'h00;
    if (rd_now && !empty_h[n-1]) begin
      bus.fifo_rd_data = fcnt[7:0];
      fcnt++;
    end
    p = n - LAT;
    if (p < 0) begin
      check_reset_vals("pre");
    end else begin
      h  = p % HT;
      v  = (p / HT) % VT;
      a  = in_active(h, v);
      m  = frame_mode(p / FT);
      xe = a ? h - 4 : 0;
      ye = a ? v - 2 : 0;
      ex = 8'h00;
      if (a) begin
        case (m)
          2'd0: if (!empty_h[p]) begin ex = sc[7:0]; sc++; end
          2'd1: ex = BARS[xe];
          2'd2: ex = (xe == 0 || ye == 0) ? 8'hFF : 8'h00;
          default: ex = solid_h[p];
        endcase
      end
      fs   = a && xe == 0 && ye == 0;
      uexp = (a && m == 2'd0 && empty_h[p]) | (uexp & ~fs);
      check("hsync", 32'(bus.hsync), (h < 2) ? 32'd0 : 32'd1);
      check("vsync", 32'(bus.vsync), (v < 1) ? 32'd0 : 32'd1);
      check("de", 32'(bus.de), 32'(a));
      check("rgb", 32'(bus.rgb), 32'(ex));
      check("x_addr", 32'(bus.x_addr), 32'(xe));
      check("y_addr", 32'(bus.y_addr), 32'(ye));
      check("frame_start", 32'(bus.frame_start), 32'(fs));
      check("underflow", 32'(bus.underflow), 32'(uexp));
    end
  endtask

  task automatic run(int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic run_to(int pos);
    for (int g = 0; g < FT && (n % FT) != pos; g++) step();
  endtask

  initial begin
    bus.mode = 2'd0; bus.solid_color = 8'h00; bus.fifo_empty = 1'b0; bus.fifo_rd_data = 8'h00;
    n = 0; sc = 0; fcnt = 0; uexp = 1'b0;
    repeat (3) @(negedge Sys_clk);
    check_reset_vals("rst");
    Rst_n = 1'b1;

    // Stream frames straight out of reset.
    run(2 * FT);

    // Bars requested on line 2: current frame stays stream, next shows bars.
    run_to(28);
    bus.mode = 2'd1;
    run(2 * FT - 28);

    bus.solid_color = 8'h5A; bus.mode = 2'd3;
    run(2 * FT);
    bus.mode = 2'd2;
    run(2 * FT);

    // Back to stream, then one empty read at pixel (3,1).
    bus.mode = 2'd0;
    run(FT);
    run_to(3 * HT + 7);
    bus.fifo_empty = 1'b1;
    step();
    bus.fifo_empty = 1'b0;
    run(2 * FT);

    // Randomised frames: mode, solid colour and FIFO empties.
    for (int fr = 0; fr < 6; fr++) begin
      bus.mode        = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      bus.solid_color = 8'($urandom);
      for (int c = 0; c < FT; c++) begin
        bus.fifo_empty = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 63) == 0) bus.mode = 2'($urandom_range(0, 3));
        step();
      end
    end
    bus.fifo_empty = 1'b0;

    // Raise underflow, then reset mid-line.
    bus.mode = 2'd0;
    run(FT);
    run_to(3 * HT + 4);
    bus.fifo_empty = 1'b1;
    step();
    bus.fifo_empty = 1'b0;
    run_to(3 * HT + 6);
    Rst_n = 1'b0;
    #1;
    check_reset_vals("async");
    repeat (3) @(negedge Sys_clk);
    check_reset_vals("hold");
    Rst_n = 1'b1;
    n = 0; sc = fcnt; uexp = 1'b0;
    run(FT + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
